hazard_sequencer: RTL and testbench
===================================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 clk  in  1: single clock; all state changes on posedge.
REQ-003 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-004 i_ic_valid  in  1: i-cache output valid this cycle (0 = fetch miss).
REQ-005 i_dc_stall  in  1: d-cache busy (miss/refill in progress).
REQ-006 i_ex_mispredict  in  1: one-cycle pulse on the first cycle a mispredicted branch occupies EX.
REQ-007 i_ex_is_load, i_ex_uses_rw  in  1 each: EX instruction is a load / writes rw.
REQ-008 i_ex_rw_addr  in  5: EX destination register.
REQ-009 i_dec_uses_rs, i_dec_uses_rt  in  1 each: decode instruction reads rs / rt.
REQ-010 i_dec_rs_addr, i_dec_rt_addr  in  5 each: decode source registers.
REQ-011 i_clr_counters  in  1: synchronous clear of both counters.
REQ-012 o_if_stall  out  1: hold PC.
REQ-013 o_i2d_stall, o_i2d_flush  out  1 each: stall/flush controls for the fetch-to-decode register.
REQ-014 o_d2e_stall, o_d2e_flush  out  1 each: stall/flush controls for the decode-to-execute register.
REQ-015 o_e2m_stall, o_e2m_flush  out  1 each: stall/flush controls for the execute-to-memory register.
REQ-016 o_m2w_stall, o_m2w_flush  out  1 each: stall/flush controls for the memory-to-writeback register.
REQ-017 o_redirect  out  1: PC redirect strobe to the recovery target.
REQ-018 o_stall_cycles  out  CNT_W: count of cycles with o_if_stall=1.
REQ-019 o_flush_events  out  CNT_W: count of o_redirect strobes.

Function
REQ-020 State machine states: RUN, MEM_WAIT, RECOVER; flag mp_pend (1 bit).
REQ-021 Load-use hazard (lu) = i_ex_is_load & i_ex_uses_rw & i_ex_rw_addr!=0 & ((i_dec_uses_rs & rs==rw) | (i_dec_uses_rt & rt==rw)).
REQ-022 Outputs are combinational from state, mp_pend and inputs; any output not asserted by REQ-023..027 is 0.
REQ-023 Priority 1, i_dc_stall=1: if/i2d/d2e/e2m stall=1, m2w_flush=1, m2w_stall=0, o_redirect=0; next state MEM_WAIT; i_ex_mispredict in this cycle sets mp_pend.
REQ-024 Priority 2, i_dc_stall=0 and (i_ex_mispredict | mp_pend): o_redirect=1, i2d_flush=1, d2e_flush=1, no stalls; clear mp_pend; next state RECOVER.
REQ-025 Priority 3, state RECOVER with no priority-1/2 condition: i2d_flush=1 (synchronous i-cache still returns the wrong-path word); next state RUN.
REQ-026 Priority 4, lu=1: if_stall=1, i2d_stall=1, d2e_flush=1; next state RUN.
REQ-027 Priority 5, i_ic_valid=0: if_stall=1, i2d_flush=1; next state RUN.
REQ-028 MEM_WAIT with i_dc_stall=0 evaluates priorities 2-5 in that cycle (no dead cycle); next state is that priority's next state.
REQ-029 A flush is never asserted together with a stall on the same register.
REQ-030 Counters increment by 1 on the qualifying cycle, saturate at all-ones, and do not wrap.
REQ-031 i_clr_counters=1 zeroes both counters next edge; clear overrides increment.

Reset
REQ-032 rst_n=0 immediately forces state=RUN, mp_pend=0, counters=0, and all stall/flush/redirect outputs=0, independent of clk.
REQ-033 Reset asserted mid-MEM_WAIT or with mp_pend=1 discards the pending redirect; the first post-reset cycle evaluates as RUN.

Verification
REQ-034 i_ic_valid=1, all hazards 0 for 10 cycles -> all controls 0; o_stall_cycles stays 0.
REQ-035 EX load rw=5, decode uses rt=5 for 1 cycle -> if_stall=1, i2d_stall=1, d2e_flush=1; o_stall_cycles=1; same case with rw=0 -> no stall.
REQ-036 i_dc_stall high 4 cycles, mispredict pulse in cycle 2 -> 4 cycles of full stall with m2w_flush=1; o_redirect=1 in cycle 5, then RECOVER i2d_flush=1 in cycle 6; o_flush_events=1.
REQ-037 Mispredict pulse coincident with lu=1 and i_ic_valid=0 -> redirect wins: i2d_flush=1, d2e_flush=1, if_stall=0.
REQ-038 Preload o_stall_cycles to 2^CNT_W-2 via long stall (CNT_W=4: 16 stall cycles) -> holds at 15; i_clr_counters with stall active -> 0 next cycle.
REQ-039 rst_n dropped asynchronously mid-cycle during MEM_WAIT with mp_pend=1 -> outputs 0 before next edge; after release no o_redirect.

Source files
------------

// File: rtl/hazard_sequencer_if.sv
// Pipeline hazard control bus: hazard sources in, per-stage stall/flush controls
// and performance counters out.
interface hazard_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_ic_valid;
  logic             i_dc_stall;
  logic             i_ex_mispredict;
  logic             i_ex_is_load;
  logic             i_ex_uses_rw;
  logic [4:0]       i_ex_rw_addr;
  logic             i_dec_uses_rs;
  logic             i_dec_uses_rt;
  logic [4:0]       i_dec_rs_addr;
  logic [4:0]       i_dec_rt_addr;
  logic             i_clr_counters;
  logic             o_if_stall;
  logic             o_i2d_stall;
  logic             o_i2d_flush;
  logic             o_d2e_stall;
  logic             o_d2e_flush;
  logic             o_e2m_stall;
  logic             o_e2m_flush;
  logic             o_m2w_stall;
  logic             o_m2w_flush;
  logic             o_redirect;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_flush_events;

  modport master (
    output i_ic_valid, i_dc_stall, i_ex_mispredict, i_ex_is_load, i_ex_uses_rw,
           i_ex_rw_addr, i_dec_uses_rs, i_dec_uses_rt, i_dec_rs_addr, i_dec_rt_addr,
           i_clr_counters,
    input  o_if_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush, o_e2m_stall,
           o_e2m_flush, o_m2w_stall, o_m2w_flush, o_redirect, o_stall_cycles,
           o_flush_events
  );

  modport slave (
    input  i_ic_valid, i_dc_stall, i_ex_mispredict, i_ex_is_load, i_ex_uses_rw,
           i_ex_rw_addr, i_dec_uses_rs, i_dec_uses_rt, i_dec_rs_addr, i_dec_rt_addr,
           i_clr_counters,
    output o_if_stall, o_i2d_stall, o_i2d_flush, o_d2e_stall, o_d2e_flush, o_e2m_stall,
           o_e2m_flush, o_m2w_stall, o_m2w_flush, o_redirect, o_stall_cycles,
           o_flush_events
  );
endinterface

// File: rtl/hazard_sequencer.sv
// Five-stage pipeline hazard sequencer: prioritised stall/flush/redirect control
// with saturating stall-cycle and redirect counters.
module hazard_sequencer #(
  parameter int unsigned CNT_W = 32
) (
  input logic               clk,
  input logic               rst_n,
  hazard_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StRun, StMemWait, StRecover} state_e;

  state_e           state_q, state_d;
  logic             mp_pend_q, mp_pend_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  logic lu;
  logic if_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush;
  logic e2m_stall, e2m_flush, m2w_stall, m2w_flush, redirect;

  assign lu = bus.i_ex_is_load & bus.i_ex_uses_rw & (bus.i_ex_rw_addr != 5'd0) &
              ((bus.i_dec_uses_rs & (bus.i_dec_rs_addr == bus.i_ex_rw_addr)) |
               (bus.i_dec_uses_rt & (bus.i_dec_rt_addr == bus.i_ex_rw_addr)));

  always_comb begin
    if_stall  = 1'b0;
    i2d_stall = 1'b0;
    i2d_flush = 1'b0;
    d2e_stall = 1'b0;
    d2e_flush = 1'b0;
    e2m_stall = 1'b0;
    e2m_flush = 1'b0;
    m2w_stall = 1'b0;
    m2w_flush = 1'b0;
    redirect  = 1'b0;
    state_d   = StRun;
    mp_pend_d = mp_pend_q;
    // Outputs drop the moment reset asserts, without waiting for a clock edge.
    if (rst_n) begin
      if (bus.i_dc_stall) begin
        if_stall  = 1'b1;
        i2d_stall = 1'b1;
        d2e_stall = 1'b1;
        e2m_stall = 1'b1;
        m2w_flush = 1'b1;
        state_d   = StMemWait;
        if (bus.i_ex_mispredict) mp_pend_d = 1'b1;
      end else if (bus.i_ex_mispredict || mp_pend_q) begin
        redirect  = 1'b1;
        i2d_flush = 1'b1;
        d2e_flush = 1'b1;
        mp_pend_d = 1'b0;
        state_d   = StRecover;
      end else if (state_q == StRecover) begin
        // The synchronous i-cache still hands back the wrong-path word this cycle.
        i2d_flush = 1'b1;
      end else if (lu) begin
        if_stall  = 1'b1;
        i2d_stall = 1'b1;
        d2e_flush = 1'b1;
      end else if (!bus.i_ic_valid) begin
        if_stall  = 1'b1;
        i2d_flush = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (bus.i_clr_counters) begin
      stall_cycles_d = '0;
      flush_events_d = '0;
    end else begin
      if (if_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (redirect && (flush_events_q != '1)) flush_events_d = flush_events_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      mp_pend_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      mp_pend_q      <= mp_pend_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign bus.o_if_stall     = if_stall;
  assign bus.o_i2d_stall    = i2d_stall;
  assign bus.o_i2d_flush    = i2d_flush;
  assign bus.o_d2e_stall    = d2e_stall;
  assign bus.o_d2e_flush    = d2e_flush;
  assign bus.o_e2m_stall    = e2m_stall;
  assign bus.o_e2m_flush    = e2m_flush;
  assign bus.o_m2w_stall    = m2w_stall;
  assign bus.o_m2w_flush    = m2w_flush;
  assign bus.o_redirect     = redirect;
  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: directed scenarios plus random traffic,
// expected controls and counters pushed per cycle and checked by a separate monitor.
module tb_hazard_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;

  hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  hazard_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ic_valid;
    logic       dc_stall;
    logic       mp;
    logic       is_load;
    logic       uses_rw;
    logic [4:0] rw;
    logic       uses_rs;
    logic       uses_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       clr;
  } stim_t;

  // Bit order: if_stall i2d_stall i2d_flush d2e_stall d2e_flush e2m_stall e2m_flush
  //            m2w_stall m2w_flush redirect
  typedef logic [9:0] ctl_t;

  typedef struct packed {
    int         tag;
    ctl_t       ctl;
    logic [3:0] sc;
    logic [3:0] fe;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;

  // Reference model: a miss or refill leaves behaviour unchanged except via the
  // deferred redirect, so only "recovering" and "redirect owed" are tracked.
  bit m_recover;
  bit m_owed;
  int m_sc;
  int m_fe;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ic_valid = 1'b1;
    return s;
  endfunction

  function automatic bit reads_reg(stim_t s, logic [4:0] r);
    return (s.uses_rs && s.rs == r) || (s.uses_rt && s.rt == r);
  endfunction

  function automatic ctl_t ref_ctl(stim_t s);
    bit lu;
    lu = s.is_load && s.uses_rw && s.rw != 0 && reads_reg(s, s.rw);
    if (s.dc_stall)            return 10'b1101010010; // hold IF..EX, bubble into WB
    if (s.mp || m_owed)        return 10'b0010100001; // redirect, squash IF/D and D/E
    if (m_recover)             return 10'b0010000000;
    if (lu)                    return 10'b1100100000;
    if (!s.ic_valid)           return 10'b1010000000;
    return '0;
  endfunction

  task automatic model_step(stim_t s, ctl_t c);
    if (s.dc_stall) begin
      if (s.mp) m_owed = 1'b1;
      m_recover = 1'b0;
    end else if (s.mp || m_owed) begin
      m_owed    = 1'b0;
      m_recover = 1'b1;
    end else begin
      m_recover = 1'b0;
    end
    if (s.clr) begin
      m_sc = 0;
      m_fe = 0;
    end else begin
      if (c[9] && m_sc < CMAX) m_sc++;
      if (c[0] && m_fe < CMAX) m_fe++;
    end
  endtask

  task automatic model_reset();
    m_recover = 1'b0;
    m_owed    = 1'b0;
    m_sc      = 0;
    m_fe      = 0;
  endtask

  task automatic apply(stim_t s);
    bus.i_ic_valid      = s.ic_valid;
    bus.i_dc_stall      = s.dc_stall;
    bus.i_ex_mispredict = s.mp;
    bus.i_ex_is_load    = s.is_load;
    bus.i_ex_uses_rw    = s.uses_rw;
    bus.i_ex_rw_addr    = s.rw;
    bus.i_dec_uses_rs   = s.uses_rs;
    bus.i_dec_uses_rt   = s.uses_rt;
    bus.i_dec_rs_addr   = s.rs;
    bus.i_dec_rt_addr   = s.rt;
    bus.i_clr_counters  = s.clr;
  endtask

  task automatic push_exp(ctl_t c);
    exp_t e;
    e.tag = tag;
    e.ctl = c;
    e.sc  = 4'(m_sc);
    e.fe  = 4'(m_fe);
    exp_q.push_back(e);
    tag++;
    ->sample_ev;
  endtask

  // One cycle: drive after the falling edge, check mid-low-phase, commit model.
  task automatic step(stim_t s);
    ctl_t c;
    @(negedge clk);
    apply(s);
    #2;
    c = ref_ctl(s);
    push_exp(c);
    model_step(s, c);
  endtask

  always @(sample_ev) begin
    exp_t e;
    ctl_t got;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got a sample with no expectation queued");
    end else begin
      e = exp_q.pop_front();
      got = {bus.o_if_stall, bus.o_i2d_stall, bus.o_i2d_flush, bus.o_d2e_stall,
             bus.o_d2e_flush, bus.o_e2m_stall, bus.o_e2m_flush, bus.o_m2w_stall,
             bus.o_m2w_flush, bus.o_redirect};
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL controls[%0d]: got %b, expected %b", e.tag, got, e.ctl);
      end
      checks++;
      if (bus.o_stall_cycles !== e.sc) begin
        errors++;
        $display("FAIL stall_cycles[%0d]: got %0d, expected %0d", e.tag, bus.o_stall_cycles, e.sc);
      end
      checks++;
      if (bus.o_flush_events !== e.fe) begin
        errors++;
        $display("FAIL flush_events[%0d]: got %0d, expected %0d", e.tag, bus.o_flush_events, e.fe);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    model_reset();
    apply(idle());
    rst_n = 1'b0;
    #2 push_exp('0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Quiet pipeline
    for (int i = 0; i < 10; i++) step(idle());

    // Load-use on rt, then the same pattern targeting r0
    s = idle();
    s.is_load = 1; s.uses_rw = 1; s.rw = 5; s.uses_rt = 1; s.rt = 5;
    step(s);
    step(idle());
    s.rw = 0; s.rt = 0;
    step(s);
    step(idle());

    // Four-cycle d-cache stall with a mispredict arriving mid-stall
    for (int i = 0; i < 4; i++) begin
      s = idle();
      s.dc_stall = 1;
      s.mp = (i == 1);
      step(s);
    end
    step(idle());
    step(idle());
    step(idle());

    // Mispredict beats a coincident load-use and fetch miss
    s = idle();
    s.mp = 1; s.ic_valid = 0;
    s.is_load = 1; s.uses_rw = 1; s.rw = 7; s.uses_rs = 1; s.rs = 7;
    step(s);
    step(idle());
    step(idle());

    // Long fetch miss drives the stall counter into saturation, then clear under stall
    s = idle();
    s.ic_valid = 0;
    for (int i = 0; i < 20; i++) step(s);
    s.clr = 1;
    step(s);
    s.clr = 0;
    step(s);
    step(idle());

    // Random traffic with small register numbers so hazards collide often
    for (int i = 0; i < 400; i++) begin
      s.ic_valid = ($urandom_range(0, 9) < 8);
      s.dc_stall = ($urandom_range(0, 9) < 2);
      s.mp       = ($urandom_range(0, 19) == 0);
      s.is_load  = $urandom_range(0, 1);
      s.uses_rw  = ($urandom_range(0, 3) != 0);
      s.rw       = 5'($urandom_range(0, 3));
      s.uses_rs  = $urandom_range(0, 1);
      s.uses_rt  = $urandom_range(0, 1);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.clr      = ($urandom_range(0, 39) == 0);
      step(s);
    end
    step(idle());
    step(idle());

    // Async reset while a refill is in progress with a redirect still owed
    s = idle();
    s.dc_stall = 1; s.mp = 1;
    step(s);
    s.mp = 0;
    step(s);
    @(negedge clk);
    apply(s);
    #1 rst_n = 1'b0;
    #1 model_reset();
    push_exp('0);
    apply(idle());
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(idle());

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
